// File: rtl/nn_pkg.sv
// Shared definitions for the time-multiplexed perceptron layer (nn_layer_seq).
//   nn_state_t  : controller states S_LOAD / S_MAC / S_ACT / S_OUT
//   OFF_BIAS,
//   OFF_THR     : per-neuron parameter offsets, added to N_INPUTS
//   acc_w()     : accumulator width for a given data width and fan-in
//   saturate()  : clamp a signed value into a DATA_W two's-complement range
package nn_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_ACT  = 2'd2,
    S_OUT  = 2'd3
  } nn_state_t;

  // Each neuron occupies N_INPUTS+2 addresses: weights first, then these.
  localparam int OFF_BIAS = 0;
  localparam int OFF_THR  = 1;

  // Full-precision sum of n_inputs products plus the shifted bias.
  function automatic int acc_w(input int data_w, input int n_inputs);
    return 2 * data_w + $clog2(n_inputs) + 1;
  endfunction

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int data_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Signed multiply-accumulate with threshold activation for nn_layer_seq.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears the accumulator)
//   clr        : load the accumulator with bias << FRAC_BITS (plus the product when add=1)
//   add        : add x*wt into the accumulator
//   x, wt      : signed operand and weight
//   bias, thr  : signed bias and threshold of the neuron being computed
//   act        : sat(acc >>> FRAC_BITS) when acc > thr << FRAC_BITS, else 0
module nn_mac_unit import nn_pkg::*; #(
  parameter int DATA_W    = 8,
  parameter int N_INPUTS  = 4,
  parameter int FRAC_BITS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] wt,
  input  logic [DATA_W-1:0] bias,
  input  logic [DATA_W-1:0] thr,
  output logic [DATA_W-1:0] act
);

  localparam int ACC_W = acc_w(DATA_W, N_INPUTS);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    bias_sh;
  logic signed [ACC_W-1:0]    thr_sh;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [63:0]         sh64;

  assign prod     = $signed(x) * $signed(wt);
  assign prod_ext = $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
  assign bias_sh  = $signed({{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias}) <<< FRAC_BITS;
  assign thr_sh   = $signed({{(ACC_W-DATA_W){thr[DATA_W-1]}}, thr}) <<< FRAC_BITS;

  // clr folds the first product in, so a neuron needs exactly N_INPUTS cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= bias_sh + (add ? prod_ext : '0);
    end else if (add) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  // Sign-extend to 64 bits before the arithmetic shift so saturate sees the true value.
  assign sh64 = $signed({{(64-ACC_W){acc_q[ACC_W-1]}}, acc_q}) >>> FRAC_BITS;
  assign act  = (acc_q > thr_sh) ? DATA_W'(saturate(sh64, DATA_W)) : '0;

endmodule

// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected perceptron layer: N_NEURONS neurons share
// one MAC that retires one product per cycle.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   prm_we/addr/wdata   : parameter write port; neuron n at base n*(N_INPUTS+2):
//                         weights 0..N_INPUTS-1, bias at N_INPUTS, threshold at N_INPUTS+1
//   prm_ready           : writes accepted (only while loading inputs)
//   in_valid/data/ready : input sample stream, N_INPUTS beats per frame
//   out_valid/data/idx  : result stream, one beat per neuron, idx = neuron number
//   out_ready           : downstream backpressure
//   chain               : only with NN_CHAIN_EN; on the final output beat, 1 feeds the
//                         results back as the next inputs and recomputes
//   busy                : high while computing or presenting results
// Optional build macro: NN_CHAIN_EN (requires N_NEURONS == N_INPUTS).
//
// Handshakes: a beat transfers on a rising edge where valid && ready are both 1.
// out_valid, once raised, holds with out_data/out_idx stable until the transfer;
// in_ready/prm_ready depend only on the state (and are 0 while reset is high).
module nn_layer_seq import nn_pkg::*; #(
  parameter  int DATA_W    = 8,
  parameter  int N_INPUTS  = 4,
  parameter  int N_NEURONS = 4,
  parameter  int FRAC_BITS = 4,
  localparam int AW        = $clog2(N_NEURONS * (N_INPUTS + 2)),
  localparam int OW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prm_we,
  input  logic [AW-1:0]     prm_addr,
  input  logic [DATA_W-1:0] prm_wdata,
  output logic              prm_ready,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [OW-1:0]     out_idx,
`ifdef NN_CHAIN_EN
  input  logic              chain,
`endif
  input  logic              out_ready,
  output logic              busy
);

  localparam int            IW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int            NPRM    = N_INPUTS + 2;
  localparam logic [IW-1:0] LAST_IN = IW'(N_INPUTS - 1);
  localparam logic [OW-1:0] LAST_N  = OW'(N_NEURONS - 1);

`ifdef NN_CHAIN_EN
  if (N_NEURONS != N_INPUTS) begin : g_chain_size_check
    $error("NN_CHAIN_EN needs N_NEURONS == N_INPUTS");
  end
`endif

  nn_state_t state;
  nn_state_t state_nx;

  // cnt: input index while loading, product index while accumulating.
  // nidx: neuron being computed, then result being presented.
  logic [IW-1:0]     cnt;
  logic [OW-1:0]     nidx;
  logic [DATA_W-1:0] w_q    [N_NEURONS][N_INPUTS];
  logic [DATA_W-1:0] bias_q [N_NEURONS];
  logic [DATA_W-1:0] thr_q  [N_NEURONS];
  logic [DATA_W-1:0] in_q   [N_INPUTS];
  logic [DATA_W-1:0] res_q  [N_NEURONS];

  logic              in_fire;
  logic              out_fire;
  logic              prm_fire;
  logic              mac_clr;
  logic              mac_add;
  logic              chain_go;
  logic [DATA_W-1:0] act;

`ifdef NN_CHAIN_EN
  assign chain_go = chain;
`else
  assign chain_go = 1'b0;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign prm_fire = prm_we & prm_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_LOAD:  if (in_fire && cnt == LAST_IN) state_nx = S_MAC;
      S_MAC:   if (cnt == LAST_IN) state_nx = S_ACT;
      S_ACT:   state_nx = (nidx == LAST_N) ? S_OUT : S_MAC;
      S_OUT:   if (out_fire && nidx == LAST_N) state_nx = chain_go ? S_MAC : S_LOAD;
      default: state_nx = S_LOAD;
    endcase
  end

  // Output / control decode
  always_comb begin
    in_ready  = 1'b0;
    prm_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mac_clr   = 1'b0;
    mac_add   = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready  = ~reset;
        prm_ready = ~reset;
      end
      S_MAC: begin
        busy    = 1'b1;
        mac_add = 1'b1;
        mac_clr = (cnt == '0);
      end
      S_ACT: busy = 1'b1;
      S_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = out_valid ? res_q[nidx] : '0;
  assign out_idx  = out_valid ? nidx : '0;

  // Datapath registers: parameters, input buffer, results, indices
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      nidx <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        bias_q[n] <= '0;
        thr_q[n]  <= '0;
        res_q[n]  <= '0;
        for (int k = 0; k < N_INPUTS; k++) w_q[n][k] <= '0;
      end
      for (int k = 0; k < N_INPUTS; k++) in_q[k] <= '0;
    end else begin
      // Out-of-range addresses match no slot and fall through harmlessly.
      if (prm_fire) begin
        for (int n = 0; n < N_NEURONS; n++) begin
          for (int k = 0; k < N_INPUTS; k++)
            if (int'(prm_addr) == n * NPRM + k) w_q[n][k] <= prm_wdata;
          if (int'(prm_addr) == n * NPRM + N_INPUTS + OFF_BIAS) bias_q[n] <= prm_wdata;
          if (int'(prm_addr) == n * NPRM + N_INPUTS + OFF_THR)  thr_q[n]  <= prm_wdata;
        end
      end
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            in_q[cnt] <= in_data;
            cnt       <= (cnt == LAST_IN) ? '0 : cnt + 1'b1;
          end
        end
        S_MAC: cnt <= (cnt == LAST_IN) ? '0 : cnt + 1'b1;
        S_ACT: begin
          res_q[nidx] <= act;
          nidx        <= (nidx == LAST_N) ? '0 : nidx + 1'b1;
        end
        S_OUT: begin
          if (out_fire) begin
            nidx <= (nidx == LAST_N) ? '0 : nidx + 1'b1;
`ifdef NN_CHAIN_EN
            if (nidx == LAST_N && chain)
              for (int k = 0; k < N_INPUTS; k++) in_q[k] <= res_q[k];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  nn_mac_unit #(
    .DATA_W   (DATA_W),
    .N_INPUTS (N_INPUTS),
    .FRAC_BITS(FRAC_BITS)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clr  (mac_clr),
    .add  (mac_add),
    .x    (in_q[cnt]),
    .wt   (w_q[nidx][cnt]),
    .bias (bias_q[nidx]),
    .thr  (thr_q[nidx]),
    .act  (act)
  );

endmodule

// File: tb/tb_nn_layer_seq.sv
// Self-checking bench for nn_layer_seq (default parameters). A frame-level
// arithmetic model fills an expected queue; one compare process checks every
// output transfer and every stalled cycle. Literal checks pin key results.
module tb_nn_layer_seq;

  localparam int DATA_W    = 8;
  localparam int N_INPUTS  = 4;
  localparam int N_NEURONS = 4;
  localparam int FRAC_BITS = 4;
  localparam int AW        = $clog2(N_NEURONS * (N_INPUTS + 2));
  localparam int OW        = $clog2(N_NEURONS);
  localparam int NPRM      = N_INPUTS + 2;
  localparam int LAT       = N_NEURONS * (N_INPUTS + 1) + 1;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              prm_we = 1'b0;
  logic [AW-1:0]     prm_addr = '0;
  logic [DATA_W-1:0] prm_wdata = '0;
  logic              prm_ready;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [OW-1:0]     out_idx;
  logic              out_ready = 1'b1;
  logic              busy;
`ifdef NN_CHAIN_EN
  logic              chain = 1'b0;
`endif

  always #5 clk = ~clk;

  nn_layer_seq #(
    .DATA_W(DATA_W), .N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .prm_we(prm_we), .prm_addr(prm_addr), .prm_wdata(prm_wdata), .prm_ready(prm_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
`ifdef NN_CHAIN_EN
    .chain(chain),
`endif
    .out_ready(out_ready), .busy(busy)
  );

  // ---------------- model and scoreboard ----------------
  int w_m [N_NEURONS][N_INPUTS];
  int b_m [N_NEURONS];
  int t_m [N_NEURONS];
  int in_m[N_INPUTS];

  logic [OW+DATA_W-1:0] exp_q[$];
  logic [OW+DATA_W-1:0] e;
  logic [DATA_W-1:0]    got[N_NEURONS];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_neuron(input int n);
    int acc;
    int r;
    acc = b_m[n] * (1 << FRAC_BITS);
    for (int k = 0; k < N_INPUTS; k++) acc += in_m[k] * w_m[n][k];
    if (acc > t_m[n] * (1 << FRAC_BITS)) begin
      r = acc >>> FRAC_BITS;
      if (r > (1 << (DATA_W - 1)) - 1) r = (1 << (DATA_W - 1)) - 1;
      if (r < -(1 << (DATA_W - 1)))    r = -(1 << (DATA_W - 1));
    end else begin
      r = 0;
    end
    return r;
  endfunction

  task automatic push_expected();
    for (int n = 0; n < N_NEURONS; n++)
      exp_q.push_back({OW'(n), DATA_W'(model_neuron(n))});
  endtask

  function automatic void clear_model();
    for (int n = 0; n < N_NEURONS; n++) begin
      b_m[n] = 0;
      t_m[n] = 0;
      for (int k = 0; k < N_INPUTS; k++) w_m[n][k] = 0;
    end
    for (int k = 0; k < N_INPUTS; k++) in_m[k] = 0;
  endfunction

  // Compare process: every transfer against the queue; every stalled cycle
  // must keep the presented beat unchanged.
  logic              stall_q = 1'b0;
  logic [DATA_W-1:0] stall_data;
  logic [OW-1:0]     stall_idx;

  always @(negedge clk) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", int'(out_valid), 1);
        check("stall_data", int'(out_data), int'(stall_data));
        check("stall_idx", int'(out_idx), int'(stall_idx));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", int'(out_idx), -1);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'($signed(out_data)), int'($signed(e[DATA_W-1:0])));
          check("out_idx", int'(out_idx), int'(e[OW+DATA_W-1:DATA_W]));
          got[out_idx] = out_data;
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_idx  = out_idx;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_prm(input int addr, input int val);
    int n;
    int o;
    prm_we    = 1'b1;
    prm_addr  = AW'(addr);
    prm_wdata = DATA_W'(val);
    tick();
    prm_we = 1'b0;
    n = addr / NPRM;
    o = addr % NPRM;
    if (n < N_NEURONS) begin
      if (o < N_INPUTS)       w_m[n][o] = val;
      else if (o == N_INPUTS) b_m[n] = val;
      else                    t_m[n] = val;
    end
  endtask

  task automatic set_all(input int w, input int b, input int t);
    for (int n = 0; n < N_NEURONS; n++) begin
      for (int k = 0; k < N_INPUTS; k++) write_prm(n * NPRM + k, w);
      write_prm(n * NPRM + N_INPUTS, b);
      write_prm(n * NPRM + N_INPUTS + 1, t);
    end
  endtask

  task automatic send(input int d);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  task automatic run_frame(input int xs[N_INPUTS], input bit do_push, input bit do_lat);
    int lat;
    for (int n = 0; n < N_NEURONS; n++) got[n] = 8'h5A;
    for (int k = 0; k < N_INPUTS; k++) begin
      send(xs[k]);
      in_m[k] = xs[k];
    end
    in_valid = 1'b0;
    if (do_push) push_expected();
    if (do_lat) begin
      lat = 1;
      while (!out_valid && lat < 200) begin
        tick();
        lat++;
      end
      check("latency", lat, LAT);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) tick();
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic wait_valid();
    for (int t = 0; t < 200 && !out_valid; t++) tick();
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_model();
    // Reset state
    repeat (2) tick();
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_prm_ready", int'(prm_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("load_in_ready", int'(in_ready), 1);
    check("load_prm_ready", int'(prm_ready), 1);
    tick();

    // Pass-through: 16*(10+20+30+40) = 1600, >>4 = 100
    set_all(16, 0, 0);
    run_frame('{10, 20, 30, 40}, 1'b1, 1'b1);
    wait_drain();
    for (int n = 0; n < N_NEURONS; n++) check("pass_lit", int'($signed(got[n])), 100);

    // Mixed signs, biases and thresholds per neuron
    for (int k = 0; k < N_INPUTS; k++) begin
      write_prm(0 * NPRM + k, (k == 0) ? 16 : (k == 1) ? -16 : (k == 2) ? 32 : 8);
      write_prm(1 * NPRM + k, (k == 0) ? -3 : (k == 1) ? 7 : (k == 2) ? -1 : 2);
      write_prm(2 * NPRM + k, (k == 0) ? 127 : (k == 1) ? -128 : (k == 2) ? 1 : 0);
      write_prm(3 * NPRM + k, 0);
    end
    write_prm(0 * NPRM + 4, 5);   write_prm(0 * NPRM + 5, -10);
    write_prm(1 * NPRM + 4, -2);  write_prm(1 * NPRM + 5, -128);
    write_prm(2 * NPRM + 4, 127); write_prm(2 * NPRM + 5, 0);
    write_prm(3 * NPRM + 4, -1);  write_prm(3 * NPRM + 5, -5);
    run_frame('{3, -7, 12, -100}, 1'b1, 1'b0);
    wait_drain();
    check("mix_n0_below_thr", int'($signed(got[0])), 0);    // -176 vs -160
    check("mix_n1_floor", int'($signed(got[1])), -19);      // -302 >>> 4
    check("mix_n2_sat", int'($signed(got[2])), 127);        // 3321 >>> 4 = 207
    check("mix_n3_bias_only", int'($signed(got[3])), -1);   // -16 >>> 4

    // Threshold cases plus backpressure on beat 2
    set_all(16, 0, 0);
    for (int k = 0; k < N_INPUTS; k++) write_prm(1 * NPRM + k, -16);
    write_prm(2 * NPRM + 5, 100);
    out_ready = 1'b0;
    run_frame('{10, 20, 30, 40}, 1'b1, 1'b0);
    wait_valid();
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd77;
    prm_we    = 1'b1;
    prm_addr  = '0;
    prm_wdata = 8'd55;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_idx", int'(out_idx), 2);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_prm_ready", int'(prm_ready), 0);
      tick();
    end
    in_valid  = 1'b0;
    prm_we    = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    check("thr_neg_weights", int'($signed(got[1])), 0);
    check("thr_equal", int'($signed(got[2])), 0);

    // Threshold 99 passes 1600 > 1584; the dropped write must not have landed
    write_prm(2 * NPRM + 5, 99);
    write_prm(27, 33);            // beyond the parameter map: ignored
    run_frame('{10, 20, 30, 40}, 1'b1, 1'b0);
    wait_drain();
    check("thr_99", int'($signed(got[2])), 100);
    check("dropped_write", int'($signed(got[0])), 100);

    // Positive saturation: 4*127*127 >>> 4 = 4032
    set_all(127, 0, 0);
    run_frame('{127, 127, 127, 127}, 1'b1, 1'b0);
    wait_drain();
    for (int n = 0; n < N_NEURONS; n++) check("sat_pos", int'($signed(got[n])), 127);

    // Large negative sum (-65024) never exceeds a threshold of -128<<4, so 0
    set_all(-128, 0, -128);
    run_frame('{127, 127, 127, 127}, 1'b1, 1'b0);
    wait_drain();
    check("sat_neg_gated", int'($signed(got[0])), 0);

    // Reset during accumulation, then a fresh load with cleared parameters
    set_all(16, 3, 0);
    run_frame('{10, 20, 30, 40}, 1'b0, 1'b0);
    tick();
    tick();
    check("mid_mac_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_data", int'(out_data), 0);
    check("abort_in_ready", int'(in_ready), 0);
    reset = 1'b0;
    clear_model();
    #1;
    check("abort_reload_ready", int'(in_ready), 1);
    run_frame('{10, 20, 30, 40}, 1'b1, 1'b1);
    wait_drain();
    check("cleared_params", int'($signed(got[3])), 0);

`ifdef NN_CHAIN_EN
    // Chain: first pass 16*10>>4 = 10, second pass on inputs 10s: 16*40>>4 = 40
    set_all(16, 0, 0);
    chain = 1'b1;
    run_frame('{1, 2, 3, 4}, 1'b1, 1'b0);
    for (int k = 0; k < N_INPUTS; k++) in_m[k] = model_neuron(k);
    push_expected();
    for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
      tick();
      if (exp_q.size() <= N_NEURONS) chain = 1'b0;
    end
    if (exp_q.size() > 0) begin
      check("chain_drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    chain = 1'b0;
    for (int n = 0; n < N_NEURONS; n++) check("chain_pass2", int'($signed(got[n])), 40);
`endif

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
